l2_lane_feeder: RTL and testbench
=================================

# l2_lane_feeder

Feature-lane producer for the distance datapath. It captures one query vector and one sample vector on `start`, then streams their per-dimension squared differences four lanes per beat: `first_l2`, `second_l2`, `third_l2` and `fourth_l2`. These feed the four-input sub-distance accumulator directly. It sits between the feature/sample memory front end and the accumulator, and uses a valid/ready beat handshake so downstream can stall.

## Interface
- `Bit`, 18: sub-distance width; each lane output is `Bit-2` bits wide.
- `FW`, 8: feature element width, unsigned. Requires `2*FW <= Bit-2`.
- `DIM`, 8: dimensions per vector. Must be a multiple of 4 and at least 4.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: request to capture the vectors and begin streaming.
- `query`  in  `DIM*FW`: dimension d is at bits `[d*FW +: FW]`.
- `sample`  in  `DIM*FW`: same layout as `query`.
- `out_ready`  in  1: downstream accepts the current beat.
- `first_l2`, `second_l2`, `third_l2`, `fourth_l2`  out  `Bit-2` each: lane values for dimensions 4k, 4k+1, 4k+2 and 4k+3.
- `beat_valid`  out  1: lane outputs hold a valid beat.
- `beat_last`  out  1: the current beat is the final beat, k = DIM/4-1.
- `busy`  out  1: a vector is being streamed.
- `done`  out  1: one-cycle pulse after the final beat is accepted.

## Operation
- State machine: IDLE, RUN.
- IDLE: `busy=0`, `beat_valid=0`.
  - `start=1` at an edge captures `query` and `sample` into internal registers and sets beat index k=0.
  - The block enters RUN with beat 0 already on the lane outputs.
- RUN: `busy=1`, `beat_valid=1`.
  - Lane j of beat k = (q[4k+j] − s[4k+j])², computed with an FW+1-bit signed difference and a 2·FW-bit unsigned square, then zero-extended to `Bit-2` bits.
  - Beat accepted when `beat_valid && out_ready` at an edge.
  - On a non-final accept: k increments and the next beat is presented.
  - On a final accept: back to IDLE, lanes cleared to 0, `done` pulsed.
- `beat_last = beat_valid && (k == DIM/4-1)`.
- `out_ready=0` in RUN: all outputs and k hold unchanged; no beat is dropped or repeated.
- `start` in RUN is ignored. Captured vectors are not disturbed, and input vector changes after capture have no effect.
- `start` in the cycle where `done=1` (state is IDLE) is accepted normally, giving back-to-back vectors with one bubble cycle.
- Reset (`rst=0` at an edge), at any time including mid-stream:
  - state IDLE, k=0;
  - all lanes 0;
  - `beat_valid`, `beat_last`, `busy`, `done` all 0;
  - captured vectors cleared to 0.
- Reset takes priority over `start` and `out_ready`.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Start latency: `start` sampled at edge E0 gives `beat_valid=1` with beat 0 immediately after E0.
- Throughput: one beat per cycle while `out_ready=1`.
- With `out_ready` held high and N = DIM/4:
  - beats are accepted at edges E1…EN;
  - after EN: `done=1`, `busy=0`, `beat_valid=0`;
  - after EN+1: `done=0`.
- Stalls extend the sequence by exactly one cycle per stalled cycle.
- Reset values of all outputs: 0.

## Configuration
- Macro `KNN_L1_DIST_EN`.
- Defined: lane value is |q − s|, FW bits zero-extended to `Bit-2`. No multiplier is built; the rest of the behaviour and timing is identical.
- Undefined (default): squared difference as specified above.

## Test plan
- Basic stream: defaults, all q=10, all s=7, `start` pulse, `out_ready=1` → two beats, each with all four lanes = 9. `beat_last` is 0 then 1. `done` pulses one cycle after E2, and `busy` is high exactly during the beats.
- Stall: q=[1,2,3,4,5,6,7,8], s=0, `out_ready` low for 3 cycles after start → beat 0 (1, 4, 9, 16) held for 3 cycles, then beat 1 (25, 36, 49, 64). `done` arrives 3 cycles later than in the unstalled case.
- Extremes: q=255, s=0 in dimension 0, and q=0, s=255 in dimension 5 → `first_l2` of beat 0 = 65025 (0xFE01), `second_l2` of beat 1 = 65025, all other lanes 0.
- Ignored start: `start` reasserted in beat 0 with new vectors → the stream uses the original vectors. `start` asserted in the `done` cycle → a new stream begins on the next cycle.
- Reset mid-stream: `rst=0` during beat 0 → all outputs 0 on the next cycle. After release, a new `start` streams correctly.
- L1 build: `KNN_L1_DIST_EN` defined, q=255, s=0, and q=3, s=10 → lanes 255 and 7.

Source files
------------

// File: rtl/l2_lane_feeder.sv
// ============================================================================
// Module : l2_lane_feeder
// Brief  : Streams per-dimension squared (or, with KNN_L1_DIST_EN, absolute)
//          query/sample differences four lanes per beat over valid/ready.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_lane_feeder #(
  parameter int Bit = 18,
  parameter int FW  = 8,
  parameter int DIM = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DIM*FW-1:0]   query,
  input  logic [DIM*FW-1:0]   sample,
  input  logic                out_ready,
  output logic [Bit-3:0]      first_l2,
  output logic [Bit-3:0]      second_l2,
  output logic [Bit-3:0]      third_l2,
  output logic [Bit-3:0]      fourth_l2,
  output logic                beat_valid,
  output logic                beat_last,
  output logic                busy,
  output logic                done
);

  localparam int c_NB = DIM / 4;
  localparam int c_KW = (c_NB > 1) ? $clog2(c_NB) : 1;
  localparam logic [c_KW-1:0] c_LAST = c_KW'(c_NB - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              r_state, w_state;
  logic [c_KW-1:0]     r_k, w_k, w_src_k;
  logic [DIM*FW-1:0]   r_q, r_s, w_q, w_s, w_src_q, w_src_s;
  logic [Bit-3:0]      r_lane [4];
  logic [Bit-3:0]      w_lane [4];
  logic [Bit-3:0]      w_calc [4];
  logic                r_valid, w_valid;
  logic                r_last, w_last;
  logic                r_busy, w_busy;
  logic                r_done, w_done;

  function automatic logic [Bit-3:0] lane_val(input logic [FW-1:0] a,
                                              input logic [FW-1:0] b);
    logic signed [FW:0] diff;
    logic [FW:0]        neg;
    logic [FW-1:0]      mag;
`ifndef KNN_L1_DIST_EN
    logic [2*FW-1:0]    sq;
`endif
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    neg  = -diff;
    mag  = diff[FW] ? neg[FW-1:0] : diff[FW-1:0];
    lane_val = '0;
`ifdef KNN_L1_DIST_EN
    lane_val[FW-1:0] = mag;
`else
    sq = {{FW{1'b0}}, mag} * {{FW{1'b0}}, mag};
    lane_val[2*FW-1:0] = sq;
`endif
    return lane_val;
  endfunction

  // Lanes for the beat about to be presented: beat 0 of the live inputs when
  // starting, otherwise the next beat of the captured vectors.
  always_comb begin
    if (r_state == IDLE) begin
      w_src_q = query;
      w_src_s = sample;
      w_src_k = '0;
    end else begin
      w_src_q = r_q;
      w_src_s = r_s;
      w_src_k = (r_k == c_LAST) ? '0 : r_k + c_KW'(1);
    end
    for (int j = 0; j < 4; j++) begin
      w_calc[j] = lane_val(w_src_q[(4*int'(w_src_k)+j)*FW +: FW],
                           w_src_s[(4*int'(w_src_k)+j)*FW +: FW]);
    end
  end

  always_comb begin
    w_state = r_state;
    w_k     = r_k;
    w_q     = r_q;
    w_s     = r_s;
    w_valid = r_valid;
    w_last  = r_last;
    w_busy  = r_busy;
    w_done  = 1'b0;
    for (int j = 0; j < 4; j++) w_lane[j] = r_lane[j];

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state = RUN;
          w_q     = query;
          w_s     = sample;
          w_k     = '0;
          w_valid = 1'b1;
          w_busy  = 1'b1;
          w_last  = (c_LAST == '0);
          for (int j = 0; j < 4; j++) w_lane[j] = w_calc[j];
        end
      end
      RUN: begin
        if (out_ready) begin
          if (r_k == c_LAST) begin
            w_state = IDLE;
            w_k     = '0;
            w_valid = 1'b0;
            w_busy  = 1'b0;
            w_last  = 1'b0;
            w_done  = 1'b1;
            for (int j = 0; j < 4; j++) w_lane[j] = '0;
          end else begin
            w_k    = w_src_k;
            w_last = (w_src_k == c_LAST);
            for (int j = 0; j < 4; j++) w_lane[j] = w_calc[j];
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_q     <= '0;
      r_s     <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int j = 0; j < 4; j++) r_lane[j] <= '0;
    end else begin
      r_state <= w_state;
      r_k     <= w_k;
      r_q     <= w_q;
      r_s     <= w_s;
      r_valid <= w_valid;
      r_last  <= w_last;
      r_busy  <= w_busy;
      r_done  <= w_done;
      for (int j = 0; j < 4; j++) r_lane[j] <= w_lane[j];
    end
  end

  assign first_l2   = r_lane[0];
  assign second_l2  = r_lane[1];
  assign third_l2   = r_lane[2];
  assign fourth_l2  = r_lane[3];
  assign beat_valid = r_valid;
  assign beat_last  = r_last;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_l2_lane_feeder.sv
// ============================================================================
// Module : tb_l2_lane_feeder
// Brief  : Self-checking bench for l2_lane_feeder (honours KNN_L1_DIST_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_lane_feeder;

  localparam int Bit = 18;
  localparam int FW  = 8;
  localparam int DIM = 8;
  localparam int NB  = DIM / 4;

`ifdef KNN_L1_DIST_EN
  localparam int E_BASIC = 3;
  localparam int E_BIG   = 255;
  localparam int E_SEVEN = 7;
  localparam int E_A0    = 5;
  localparam int E_A4    = 13;
  localparam int E_B0    = 200;
  localparam int E_ST0 [4] = '{1, 2, 3, 4};
  localparam int E_ST1 [4] = '{5, 6, 7, 8};
`else
  localparam int E_BASIC = 9;
  localparam int E_BIG   = 65025;
  localparam int E_SEVEN = 49;
  localparam int E_A0    = 25;
  localparam int E_A4    = 169;
  localparam int E_B0    = 40000;
  localparam int E_ST0 [4] = '{1, 4, 9, 16};
  localparam int E_ST1 [4] = '{25, 36, 49, 64};
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic [DIM*FW-1:0] query;
  logic [DIM*FW-1:0] sample;
  logic              out_ready;
  logic [Bit-3:0]    first_l2, second_l2, third_l2, fourth_l2;
  logic              beat_valid, beat_last, busy, done;
  logic [Bit-3:0]    lo [4];

  int n_chk  = 0;
  int n_fail = 0;

  l2_lane_feeder #(.Bit(Bit), .FW(FW), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .query(query), .sample(sample),
    .out_ready(out_ready), .first_l2(first_l2), .second_l2(second_l2),
    .third_l2(third_l2), .fourth_l2(fourth_l2), .beat_valid(beat_valid),
    .beat_last(beat_last), .busy(busy), .done(done)
  );

  assign lo[0] = first_l2;
  assign lo[1] = second_l2;
  assign lo[2] = third_l2;
  assign lo[3] = fourth_l2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_ref(input int a, input int b);
    int d = a - b;
`ifdef KNN_L1_DIST_EN
    return (d < 0) ? -d : d;
`else
    return d * d;
`endif
  endfunction

  // Stream-level reference: a captured vector pair and the beat on show.
  bit m_run  = 0;
  bit m_done = 0;
  int m_k    = 0;
  int mq [DIM];
  int ms [DIM];

  initial for (int d = 0; d < DIM; d++) begin mq[d] = 0; ms[d] = 0; end

  always @(negedge clk) begin
    cmp("beat_valid", int'(beat_valid), int'(m_run));
    cmp("busy", int'(busy), int'(m_run));
    cmp("beat_last", int'(beat_last), int'(m_run && (m_k == NB - 1)));
    cmp("done", int'(done), int'(m_done));
    for (int j = 0; j < 4; j++)
      cmp($sformatf("lane%0d", j), int'(lo[j]),
          m_run ? lane_ref(mq[4*m_k+j], ms[4*m_k+j]) : 0);

    // Inputs are stable here and are what the next rising edge will sample.
    m_done = 0;
    if (!rst) begin
      m_run = 0;
      m_k   = 0;
      for (int d = 0; d < DIM; d++) begin mq[d] = 0; ms[d] = 0; end
    end else if (!m_run) begin
      if (start) begin
        for (int d = 0; d < DIM; d++) begin
          mq[d] = int'(query[d*FW +: FW]);
          ms[d] = int'(sample[d*FW +: FW]);
        end
        m_run = 1;
        m_k   = 0;
      end
    end else if (out_ready) begin
      if (m_k == NB - 1) begin
        m_run  = 0;
        m_done = 1;
        m_k    = 0;
      end else begin
        m_k++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int qv, input int sv);
    for (int d = 0; d < DIM; d++) begin
      query[d*FW +: FW]  = FW'(qv);
      sample[d*FW +: FW] = FW'(sv);
    end
  endtask

  task automatic set_dim(input int d, input int qv, input int sv);
    query[d*FW +: FW]  = FW'(qv);
    sample[d*FW +: FW] = FW'(sv);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; query = '0; sample = '0;
    step();
    @(negedge clk);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_lane0", int'(first_l2), 0);
    step();
    rst = 1'b1;

    // Basic stream
    out_ready = 1'b1; fill(10, 7); start = 1'b1;
    step(); start = 1'b0;
    @(negedge clk);
    cmp("basic_b0_valid", int'(beat_valid), 1);
    cmp("basic_b0_lane0", int'(first_l2), E_BASIC);
    cmp("basic_b0_last", int'(beat_last), 0);
    step();
    @(negedge clk);
    cmp("basic_b1_last", int'(beat_last), 1);
    cmp("basic_b1_lane3", int'(fourth_l2), E_BASIC);
    step();
    @(negedge clk);
    cmp("basic_done", int'(done), 1);
    cmp("basic_busy_low", int'(busy), 0);
    step();
    @(negedge clk);
    cmp("basic_done_clear", int'(done), 0);

    // Stall
    step();
    out_ready = 1'b0; fill(0, 0);
    for (int d = 0; d < DIM; d++) set_dim(d, d + 1, 0);
    start = 1'b1;
    step(); start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++)
        cmp($sformatf("stall_hold_lane%0d", j), int'(lo[j]), E_ST0[j]);
      step();
    end
    out_ready = 1'b1;
    step();
    @(negedge clk);
    for (int j = 0; j < 4; j++)
      cmp($sformatf("stall_b1_lane%0d", j), int'(lo[j]), E_ST1[j]);
    step();
    @(negedge clk);
    cmp("stall_done", int'(done), 1);

    // Extremes and L1 pins
    step();
    fill(0, 0); set_dim(0, 255, 0); set_dim(5, 0, 255);
    start = 1'b1;
    step(); start = 1'b0;
    @(negedge clk);
    cmp("ext_b0_lane0", int'(first_l2), E_BIG);
    cmp("ext_b0_lane1", int'(second_l2), 0);
    step();
    @(negedge clk);
    cmp("ext_b1_lane1", int'(second_l2), E_BIG);
    cmp("ext_b1_lane0", int'(first_l2), 0);
    step(); step();
    fill(0, 0); set_dim(0, 255, 0); set_dim(1, 3, 10);
    start = 1'b1;
    step(); start = 1'b0;
    @(negedge clk);
    cmp("l1_lane0", int'(first_l2), E_BIG);
    cmp("l1_lane1", int'(second_l2), E_SEVEN);
    step(); step(); step();

    // Ignored start in RUN, then start in the done cycle
    for (int d = 0; d < DIM; d++) set_dim(d, d * 3 + 5, d);
    start = 1'b1;
    step();
    fill(200, 0);
    @(negedge clk);
    cmp("ign_b0_lane0", int'(first_l2), E_A0);
    step();
    @(negedge clk);
    cmp("ign_b1_lane0", int'(first_l2), E_A4);
    step();
    @(negedge clk);
    cmp("ign_done", int'(done), 1);
    step(); start = 1'b0;
    @(negedge clk);
    cmp("b2b_valid", int'(beat_valid), 1);
    cmp("b2b_lane0", int'(first_l2), E_B0);
    step(); step(); step();

    // Reset mid-stream
    fill(9, 1); start = 1'b1;
    step(); start = 1'b0; rst = 1'b0;
    step(); rst = 1'b1;
    @(negedge clk);
    cmp("rst_mid_valid", int'(beat_valid), 0);
    cmp("rst_mid_lane0", int'(first_l2), 0);
    fill(10, 7); start = 1'b1;
    step(); start = 1'b0;
    @(negedge clk);
    cmp("rst_restart_lane2", int'(third_l2), E_BASIC);
    step(); step(); step();

    // Random traffic
    repeat (600) begin
      rst       = ($urandom_range(0, 59) != 0);
      start     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int d = 0; d < DIM; d++)
        set_dim(d, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      step();
    end
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
